// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int BEATS = 4;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester, memory-port and status signals of dmem_arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8
);
  logic              r0_req;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_gnt;
  logic              r0_done;
  logic [DATA_W-1:0] r0_rdata;

  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_gnt;
  logic              r1_done;
  logic [DATA_W-1:0] r1_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BYTE_W-1:0] mem_wdata;
  logic [BYTE_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  mem_rdata,
    output r0_gnt, r0_done, r0_rdata,
    output r1_gnt, r1_done, r1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output mem_rdata,
    input  r0_gnt, r0_done, r0_rdata,
    input  r1_gnt, r1_done, r1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin pick; pointer is held by the parent
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  req_id_t    i_ptr,
  output logic [1:0] o_grant,
  output req_id_t    o_winner
);

  always_comb begin
    o_winner = REQ0;
    if (i_req == 2'b11) begin
      o_winner = i_ptr;
    end else if (i_req[1]) begin
      o_winner = REQ1;
    end
    o_grant = 2'b00;
    if (|i_req) begin
      o_grant = (o_winner == REQ1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares a byte-wide memory between two word requesters, four little-endian beats per access
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8
) (
  input logic           clock,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  state_t              r_state;
  logic [1:0]          r_beat;
  req_id_t             r_ptr;
  req_id_t             r_owner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-BYTE_W-1:0] r_buf;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;

  logic [1:0]          w_req;
  logic [1:0]          w_grant;
  req_id_t             w_winner;
  logic                w_idle;
  logic                w_xfer;
  logic [BYTE_W-1:0]   w_wbyte;

  assign w_req = {bus.r1_req, bus.r0_req};

  rr_arbiter2 u_rr (
    .i_req    (w_req),
    .i_ptr    (r_ptr),
    .o_grant  (w_grant),
    .o_winner (w_winner)
  );

  always_comb begin
    w_wbyte = '0;
    case (r_beat)
      2'd0: w_wbyte = r_wdata[0*BYTE_W +: BYTE_W];
      2'd1: w_wbyte = r_wdata[1*BYTE_W +: BYTE_W];
      2'd2: w_wbyte = r_wdata[2*BYTE_W +: BYTE_W];
      2'd3: w_wbyte = r_wdata[3*BYTE_W +: BYTE_W];
      default: w_wbyte = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_beat   <= 2'd0;
      r_ptr    <= REQ0;
      r_owner  <= REQ0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_buf    <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_owner <= w_winner;
            r_we    <= (w_winner == REQ1) ? bus.r1_we    : bus.r0_we;
            r_addr  <= (w_winner == REQ1) ? bus.r1_addr  : bus.r0_addr;
            r_wdata <= (w_winner == REQ1) ? bus.r1_wdata : bus.r0_wdata;
            r_ptr   <= (w_winner == REQ1) ? REQ0 : REQ1;
            r_beat  <= 2'd0;
            r_state <= XFER;
          end
        end
        XFER: begin
          // read data lags the strobe by one cycle, so beat n lands byte n-1
          if (!r_we) begin
            case (r_beat)
              2'd1: r_buf[0*BYTE_W +: BYTE_W] <= bus.mem_rdata;
              2'd2: r_buf[1*BYTE_W +: BYTE_W] <= bus.mem_rdata;
              2'd3: r_buf[2*BYTE_W +: BYTE_W] <= bus.mem_rdata;
              default: ;
            endcase
          end
          r_beat <= r_beat + 2'd1;
          if (r_beat == 2'(BEATS - 1)) begin
            r_state <= r_we ? DONE : CAPT;
          end
        end
        CAPT: begin
          if (r_owner == REQ1) begin
            r_rdata1 <= {bus.mem_rdata, r_buf};
          end else begin
            r_rdata0 <= {bus.mem_rdata, r_buf};
          end
          r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_idle = (r_state == IDLE);
  assign w_xfer = (r_state == XFER);

  // grant is combinational in IDLE; reset masks it so every output is low while reset is held
  assign bus.r0_gnt   = w_idle & ~reset & w_grant[0];
  assign bus.r1_gnt   = w_idle & ~reset & w_grant[1];
  assign bus.r0_done  = (r_state == DONE) & (r_owner == REQ0);
  assign bus.r1_done  = (r_state == DONE) & (r_owner == REQ1);
  assign bus.r0_rdata = r_rdata0;
  assign bus.r1_rdata = r_rdata1;

  assign bus.mem_en    = w_xfer;
  assign bus.mem_we    = w_xfer & r_we;
  assign bus.mem_addr  = w_xfer ? (r_addr + ADDR_W'(r_beat)) : '0;
  assign bus.mem_wdata = w_xfer ? w_wbyte : '0;
  assign bus.busy      = ~w_idle;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a transaction-level memory model
module tb_dmem_arbiter;

  logic        clock;
  logic        reset;
  logic        mem_init;
  int          cyc;
  int          checks;
  int          errors;
  int          last_srv;
  int          gnt_cyc;
  int          prev_gnt_cyc;
  logic [7:0]  mem [256];
  logic [7:0]  ref_mem [256];
  logic [31:0] exp_rd0;
  logic [31:0] exp_rd1;

  typedef struct {
    logic        who;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [5];

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      bus.mem_rdata <= 8'h00;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  function automatic logic [86:0] obs();
    return {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy,
            bus.r0_gnt, bus.r1_gnt, bus.r0_done, bus.r1_done, bus.r0_rdata, bus.r1_rdata};
  endfunction

  function automatic logic [86:0] ev(input logic en, input logic we, input logic [7:0] a,
                                     input logic [7:0] wd, input logic bz,
                                     input logic [1:0] g, input logic [1:0] dn);
    return {en, we, a, wd, bz, g[0], g[1], dn[0], dn[1], exp_rd0, exp_rd1};
  endfunction

  task automatic chk(input string nm, input logic [86:0] act, input logic [86:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic rq, input logic we,
                         input logic [7:0] a, input logic [31:0] d);
    if (i == 0) begin
      bus.r0_req = rq; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
    end else begin
      bus.r1_req = rq; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
    end
  endtask

  // One access from IDLE: winner chosen by "whoever was not served last", memory bytes from ref_mem.
  task automatic txn(input string nm, input logic [1:0] mask, input logic [1:0] hold,
                     input logic [1:0] raise,
                     input logic we0, input logic [7:0] a0, input logic [31:0] d0,
                     input logic we1, input logic [7:0] a1, input logic [31:0] d1);
    int          w;
    int          last_c;
    logic        twe;
    logic [7:0]  ta;
    logic [31:0] td;
    logic [31:0] rword;
    logic [86:0] e;
    w = (mask == 2'b11) ? 1 - last_srv : (mask[1] ? 1 : 0);
    last_srv = w;
    twe = (w == 1) ? we1 : we0;
    ta  = (w == 1) ? a1 : a0;
    td  = (w == 1) ? d1 : d0;
    for (int i = 0; i < 4; i++) rword[8*i +: 8] = ref_mem[(int'(ta) + i) % 256];
    @(negedge clock);
    set_req(0, mask[0], we0, a0, d0);
    set_req(1, mask[1], we1, a1, d1);
    #1;
    prev_gnt_cyc = gnt_cyc;
    gnt_cyc = cyc;
    chk($sformatf("%s gnt", nm), obs(), ev(1'b0, 1'b0, 8'h00, 8'h00, 1'b0,
        (w == 1) ? 2'b10 : 2'b01, 2'b00));
    last_c = twe ? 5 : 6;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        if (!hold[i]) begin
          if (raise[i] && c >= 2)
            set_req(i, 1'b1, (i == 1) ? we1 : we0, (i == 1) ? a1 : a0, (i == 1) ? d1 : d0);
          else
            set_req(i, (c < last_c) ? 1'($urandom_range(0, 1)) : 1'b0,
                    1'($urandom_range(0, 1)), 8'($urandom), $urandom);
        end
      end
      #1;
      if (c <= 4) begin
        e = ev(1'b1, twe, ta + 8'(c - 1), td[8*(c-1) +: 8], 1'b1, 2'b00, 2'b00);
      end else if (c < last_c) begin
        e = ev(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 2'b00, 2'b00);
      end else begin
        if (!twe) begin
          if (w == 1) exp_rd1 = rword;
          else exp_rd0 = rword;
        end
        e = ev(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 2'b00, (w == 1) ? 2'b10 : 2'b01);
      end
      chk($sformatf("%s c%0d", nm, c), obs(), e);
    end
    if (twe) for (int i = 0; i < 4; i++) ref_mem[(int'(ta) + i) % 256] = td[8*i +: 8];
  endtask

  initial begin
    logic [31:0] act;
    checks = 0; errors = 0; last_srv = 1;
    gnt_cyc = 0; prev_gnt_cyc = 0;
    exp_rd0 = 32'h0; exp_rd1 = 32'h0;
    reset = 1'b1; mem_init = 1'b1;
    set_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
    set_req(1, 1'b0, 1'b0, 8'h00, 32'h0);
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    tbl[0] = '{1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b1, 8'hFE, 32'h11223344, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 8'hFE, 32'h0,        32'h11223344};
    tbl[4] = '{1'b0, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF};

    @(negedge clock); #1;
    chk("reset state", obs(), 87'h0);
    @(negedge clock);
    reset = 1'b0; mem_init = 1'b0;

    // Arbitration from the first IDLE after reset: r0, then r1 (held), then alternating.
    txn("arb1", 2'b11, 2'b10, 2'b00, 1'b1, 8'h40, 32'hA0A1A2A3, 1'b1, 8'h50, 32'hB0B1B2B3);
    txn("arb2", 2'b10, 2'b00, 2'b00, 1'b1, 8'h40, 32'hA0A1A2A3, 1'b1, 8'h50, 32'hB0B1B2B3);
    txn("arb3", 2'b11, 2'b00, 2'b00, 1'b0, 8'h50, 32'h0, 1'b0, 8'h40, 32'h0);
    txn("arb4", 2'b11, 2'b00, 2'b00, 1'b0, 8'h50, 32'h0, 1'b0, 8'h40, 32'h0);

    for (int k = 0; k < 5; k++) begin
      txn($sformatf("tbl%0d", k), tbl[k].who ? 2'b10 : 2'b01, 2'b00, 2'b00,
          tbl[k].we, tbl[k].addr, tbl[k].wdata, tbl[k].we, tbl[k].addr, tbl[k].wdata);
      if (!tbl[k].we) begin
        act = tbl[k].who ? bus.r1_rdata : bus.r0_rdata;
        checks++;
        if (act !== tbl[k].exp_rdata) begin
          errors++;
          $display("FAIL tbl%0d rdata: got %h expected %h", k, act, tbl[k].exp_rdata);
        end
      end
    end

    // Reset asserted during beat 2 of a write.
    @(negedge clock);
    set_req(0, 1'b1, 1'b1, 8'h80, 32'hCAFEF00D);
    set_req(1, 1'b0, 1'b0, 8'h00, 32'h0);
    #1;
    chk("rst gnt", obs(), ev(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'b01, 2'b00));
    @(negedge clock);
    set_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clock);
    @(negedge clock); #1;
    chk("rst beat2", obs(), ev(1'b1, 1'b1, 8'h82, 8'hFE, 1'b1, 2'b00, 2'b00));
    set_req(0, 1'b1, 1'b1, 8'h90, 32'h1);
    set_req(1, 1'b1, 1'b1, 8'h91, 32'h2);
    #2 reset = 1'b1;
    #1;
    exp_rd0 = 32'h0; exp_rd1 = 32'h0; last_srv = 1;
    ref_mem[8'h80] = 8'h0D; ref_mem[8'h81] = 8'hF0;
    chk("rst async", obs(), 87'h0);
    @(negedge clock); #1;
    chk("rst hold", obs(), 87'h0);
    @(negedge clock);
    reset = 1'b0;
    set_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
    set_req(1, 1'b0, 1'b0, 8'h00, 32'h0);
    #1;
    chk("rst idle", obs(), 87'h0);
    txn("rst both", 2'b11, 2'b00, 2'b00, 1'b0, 8'h80, 32'h0, 1'b0, 8'h20, 32'h0);

    // r1 streams writes with req held; r0 raises mid-transaction.
    txn("t6a", 2'b10, 2'b10, 2'b00, 1'b1, 8'h70, 32'h0, 1'b1, 8'h60, 32'h01020304);
    txn("t6b", 2'b10, 2'b10, 2'b01, 1'b1, 8'h70, 32'hA5A50001, 1'b1, 8'h64, 32'h05060708);
    chk_int("t6 interval r1", gnt_cyc - prev_gnt_cyc, 6);
    txn("t6c", 2'b11, 2'b10, 2'b00, 1'b1, 8'h70, 32'hA5A50001, 1'b1, 8'h68, 32'h090A0B0C);
    chk_int("t6 interval r0", gnt_cyc - prev_gnt_cyc, 6);
    txn("t6d", 2'b10, 2'b00, 2'b00, 1'b0, 8'h00, 32'h0, 1'b1, 8'h68, 32'h090A0B0C);
    txn("t6e", 2'b01, 2'b00, 2'b00, 1'b0, 8'h70, 32'h0, 1'b0, 8'h00, 32'h0);

    for (int n = 0; n < 40; n++) begin
      txn($sformatf("rnd%0d", n), 2'($urandom_range(1, 3)), 2'b00, 2'b00,
          1'($urandom_range(0, 1)), 8'($urandom), $urandom,
          1'($urandom_range(0, 1)), 8'($urandom), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
